// File: rtl/register_file_param.sv
// ============================================================================
//  Module   : register_file_param
//  Brief    : Parametrised register file with two registered read ports, one
//             write port, write-to-read bypass, optional hardwired-zero
//             register 0 and a multi-cycle bulk-clear sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_param #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  E,
    input  logic [ADDR_WIDTH-1:0] read_register1,
    input  logic [ADDR_WIDTH-1:0] read_register2,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  register_write,
    input  logic                  clear_start,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  busy
);

    localparam int                    DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rd1_q;
    logic [DATA_WIDTH-1:0]   rd2_q;
    logic [DATA_WIDTH-1:0]   rd1_d;
    logic [DATA_WIDTH-1:0]   rd2_d;
    logic                    w_zero_wr;
    logic                    w_wr_accept;

    // Write acceptance and read-data selection (array, bypass, hardwired zero)
    always_comb begin
        w_zero_wr   = (ZERO_REG != 0) && (write_register == '0);
        // Clear has priority over a same-cycle write; a dropped write must
        // not bypass either, so bypass keys off the accepted write only.
        w_wr_accept = (state_q == S_IDLE) && E && register_write
                      && !clear_start && !w_zero_wr;

        rd1_d = mem_q[read_register1];
        if (w_wr_accept && (read_register1 == write_register)) begin
            rd1_d = write_data;
        end
        if ((ZERO_REG != 0) && (read_register1 == '0)) begin
            rd1_d = '0;
        end

        rd2_d = mem_q[read_register2];
        if (w_wr_accept && (read_register2 == write_register)) begin
            rd2_d = write_data;
        end
        if ((ZERO_REG != 0) && (read_register2 == '0)) begin
            rd2_d = '0;
        end
    end

    // Controller FSM, storage array and registered read ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q   <= '0;
            rd2_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (E) begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
                if (clear_start) begin
                    state_q <= S_SWEEP;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end else if (w_wr_accept) begin
                    mem_q[write_register] <= write_data;
                end
            end
        end else begin
            // One entry zeroed per cycle; E and all requests are ignored and
            // the read ports hold until the sweep completes.
            mem_q[cnt_q] <= '0;
            if (cnt_q == c_LAST) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
//  Module   : tb_register_file_param
//  Brief    : Scoreboard bench for register_file_param. Three instances:
//             64x32 with zero reg, 64x32 without zero reg, 8x8 with zero reg.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_register_file_param;

    logic        clk = 1'b0;
    logic        reset;

    // Shared stimulus for the two 64x32 instances
    logic        E, we, cs;
    logic [4:0]  rr1, rr2, wr;
    logic [63:0] wd;
    logic [63:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic        busy_0, busy_1;

    // Stimulus for the 8x8 instance
    logic        e8, we8, cs8;
    logic [2:0]  rr1_8, rr2_8, wr8;
    logic [7:0]  wd8, rd1_8, rd2_8;
    logic        busy_8;

    always #5 clk = ~clk;

    register_file_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .reset(reset), .E(E),
        .read_register1(rr1), .read_register2(rr2), .write_register(wr),
        .write_data(wd), .register_write(we), .clear_start(cs),
        .read_data1(rd1_0), .read_data2(rd2_0), .busy(busy_0)
    );

    register_file_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(0)) u_dut1 (
        .clk(clk), .reset(reset), .E(E),
        .read_register1(rr1), .read_register2(rr2), .write_register(wr),
        .write_data(wd), .register_write(we), .clear_start(cs),
        .read_data1(rd1_1), .read_data2(rd2_1), .busy(busy_1)
    );

    register_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .reset(reset), .E(e8),
        .read_register1(rr1_8), .read_register2(rr2_8), .write_register(wr8),
        .write_data(wd8), .register_write(we8), .clear_start(cs8),
        .read_data1(rd1_8), .read_data2(rd2_8), .busy(busy_8)
    );

    // ------------------------------------------------------------------
    // Scoreboard: stimulus pushes expectations tagged with the falling
    // edge at which they become observable; the monitor pops and compares.
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        int          dut;
        int          port;   // 1 = read_data1, 2 = read_data2, 3 = busy
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   ncyc     = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [63:0] observe(input int dut, input int port);
        logic [63:0] v;
        v = '0;
        case (dut)
            0: v = (port == 1) ? rd1_0 : (port == 2) ? rd2_0 : {63'd0, busy_0};
            1: v = (port == 1) ? rd1_1 : (port == 2) ? rd2_1 : {63'd0, busy_1};
            default: v = (port == 1) ? {56'd0, rd1_8} :
                         (port == 2) ? {56'd0, rd2_8} : {63'd0, busy_8};
        endcase
        return v;
    endfunction

    task automatic expect_val(input string name, input int dut, input int port,
                              input logic [63:0] v);
        exp_t e;
        e.due  = ncyc + 1;
        e.dut  = dut;
        e.port = port;
        e.exp  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        ncyc = ncyc + 1;
        while (sb_q.size() > 0 && sb_q[0].due <= ncyc) begin
            e   = sb_q.pop_front();
            act = observe(e.dut, e.port);
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    // Advance to just after the next falling edge (inputs change here)
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Assert reset away from any rising edge and expect immediate clearing
    task automatic reset_mid_cycle(input string name);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_val({name, "_rd1"},  0, 1, 64'd0);
        expect_val({name, "_rd2"},  0, 2, 64'd0);
        expect_val({name, "_busy"}, 0, 3, 64'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        E = 0; we = 0; cs = 0; rr1 = 0; rr2 = 0; wr = 0; wd = 0;
        e8 = 0; we8 = 0; cs8 = 0; rr1_8 = 0; rr2_8 = 0; wr8 = 0; wd8 = 0;
        expect_val("rst_busy", 0, 3, 64'd0);
        expect_val("rst_rd1",  0, 1, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // ---- Test 1: bypass, 1-cycle read latency, mid-cycle reset ----
        E = 1; we = 1; wr = 5'd22; wd = 64'd48; rr1 = 5'd0; rr2 = 5'd22;
        expect_val("t1_bypass_rd2", 0, 2, 64'd48);
        tick();
        we = 0; rr1 = 5'd22;
        expect_val("t1_read_rd1", 0, 1, 64'd48);
        tick();
        reset_mid_cycle("t1_async_reset");
        rr1 = 5'd22;
        expect_val("t1_array_cleared", 0, 1, 64'd0);
        tick();

        // ---- Test 2: enable gating, write strobe gating ----
        we = 1; wr = 5'd3; wd = 64'h1234; rr1 = 5'd3;
        expect_val("t2_bypass_reg3", 0, 1, 64'h1234);
        tick();
        E = 0; we = 1; wr = 5'd10; wd = 64'hDEAD; rr1 = 5'd10;
        expect_val("t2_hold_when_E0", 0, 1, 64'h1234);
        tick();
        E = 1; we = 0; rr1 = 5'd10;
        expect_val("t2_no_write_when_E0", 0, 1, 64'd0);
        tick();
        we = 0; wr = 5'd3; wd = 64'h5555; rr1 = 5'd3; rr2 = 5'd10;
        expect_val("t2_no_write_no_strobe", 0, 1, 64'h1234);
        expect_val("t2_reg10_still_zero",   0, 2, 64'd0);
        tick();

        // ---- Test 3: register zero with and without hardwiring ----
        we = 1; wr = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF; rr1 = 5'd0; rr2 = 5'd0;
        expect_val("t3_zr1_no_bypass_rd1", 0, 1, 64'd0);
        expect_val("t3_zr1_no_bypass_rd2", 0, 2, 64'd0);
        expect_val("t3_zr0_bypass_rd1",    1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_val("t3_zr0_bypass_rd2",    1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        we = 0;
        expect_val("t3_zr1_reg0_reads0",   0, 1, 64'd0);
        expect_val("t3_zr0_reg0_stored",   1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // ---- Test 4: bulk clear, busy length, ignored writes, held outputs ----
        we = 1; wr = 5'd5; wd = 64'd7;
        tick();
        wr = 5'd31; wd = 64'd9;
        tick();
        we = 0; cs = 1; rr1 = 5'd5; rr2 = 5'd31;
        expect_val("t4_clear_cycle_rd1", 0, 1, 64'd7);
        expect_val("t4_clear_cycle_rd2", 0, 2, 64'd9);
        expect_val("t4_busy_rise",       0, 3, 64'd1);
        tick();
        cs = 0;
        for (int i = 1; i < 32; i++) begin
            E = !(i >= 10 && i <= 20);
            cs = (i == 5);
            we = 1; wr = 5'd4; wd = 64'd3; rr1 = 5'd4; rr2 = 5'd0;
            expect_val("t4_busy_high", 0, 3, 64'd1);
            expect_val("t4_rd1_held",  0, 1, 64'd7);
            expect_val("t4_rd2_held",  0, 2, 64'd9);
            tick();
        end
        E = 1; cs = 0; we = 0;
        expect_val("t4_busy_fall", 0, 3, 64'd0);
        expect_val("t4_rd1_held_last", 0, 1, 64'd7);
        tick();
        rr1 = 5'd5; rr2 = 5'd31;
        expect_val("t4_reg5_cleared",  0, 1, 64'd0);
        expect_val("t4_reg31_cleared", 0, 2, 64'd0);
        expect_val("t4_busy_stays_low", 0, 3, 64'd0);
        tick();
        rr1 = 5'd4;
        expect_val("t4_reg4_write_ignored", 0, 1, 64'd0);
        tick();

        // ---- Test 5: clear/write collision, reset mid-sweep ----
        cs = 1; we = 1; wr = 5'd1; wd = 64'd5; rr1 = 5'd1; rr2 = 5'd1;
        expect_val("t5_collision_no_bypass_rd1", 0, 1, 64'd0);
        expect_val("t5_collision_no_bypass_rd2", 0, 2, 64'd0);
        tick();
        cs = 0; we = 0;
        for (int i = 1; i < 10; i++) begin
            expect_val("t5_busy_high", 0, 3, 64'd1);
            tick();
        end
        reset_mid_cycle("t5_reset_mid_sweep");
        we = 1; wr = 5'd1; wd = 64'd5; rr1 = 5'd1;
        expect_val("t5_write_after_reset", 0, 1, 64'd5);
        expect_val("t5_no_resume_busy",    0, 3, 64'd0);
        tick();
        we = 0; rr2 = 5'd1;
        expect_val("t5_readback_after_reset", 0, 2, 64'd5);
        tick();
        E = 0;

        // ---- Test 6: narrow instance, 8-bit data, 8 entries ----
        e8 = 1; we8 = 1; wr8 = 3'd7; wd8 = 8'hA5; rr1_8 = 3'd7;
        expect_val("t6_bypass_rd1", 2, 1, 64'hA5);
        tick();
        we8 = 0; rr2_8 = 3'd7;
        expect_val("t6_read_rd2", 2, 2, 64'hA5);
        tick();
        cs8 = 1;
        expect_val("t6_busy_rise", 2, 3, 64'd1);
        tick();
        cs8 = 0;
        for (int i = 1; i < 8; i++) begin
            expect_val("t6_busy_high", 2, 3, 64'd1);
            tick();
        end
        expect_val("t6_busy_fall", 2, 3, 64'd0);
        expect_val("t6_rd1_held",  2, 1, 64'hA5);
        tick();
        rr1_8 = 3'd7;
        expect_val("t6_reg7_cleared", 2, 1, 64'd0);
        tick();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            tick();
        end
        if (sb_q.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
            n_checks += sb_q.size();
            n_errors += sb_q.size();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor of the 64-bit, 32-entry register file: configurable data width and depth, two registered read ports, one write port and an enable `E`.
- Adds asynchronous reset and a write-to-read bypass.
- Adds an optional hardwired-zero register 0.
- Adds a multi-cycle bulk-clear sequencer with a busy flag.
- Sits in the datapath between decode (register addresses) and execute/writeback.

Parameters:
DATA_WIDTH, 64, width of each register and of the data ports
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 behaves like any other

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
E  input  1  enable; when 0, no reads, writes or clear starts are accepted
read_register1  input  ADDR_WIDTH  read port 1 address
read_register2  input  ADDR_WIDTH  read port 2 address
write_register  input  ADDR_WIDTH  write address
write_data  input  DATA_WIDTH  write data
register_write  input  1  write strobe
clear_start  input  1  request a bulk clear of all entries
read_data1  output  DATA_WIDTH  registered read data, port 1
read_data2  output  DATA_WIDTH  registered read data, port 2
busy  output  1  high while the clear sweep runs

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset state: asserting `reset` immediately clears every array entry, `read_data1`, `read_data2`, `busy`, the FSM (to IDLE) and the sweep counter to 0.
- Reset mid-sweep aborts the sweep; the array is zero anyway.
- FSM states: IDLE and SWEEP.
- IDLE, write: when `E`=1, `register_write`=1 and `clear_start`=0, store `write_data` into `write_register` at the edge.
  - If ZERO_REG=1 and `write_register`=0, the write is dropped.
- IDLE, read:
  - When `E`=1, each `read_dataN` loads the entry at `read_registerN` at the edge (1-cycle latency).
  - When `E`=0, outputs hold.
- Bypass: if a write is accepted in the same cycle and `read_registerN` == `write_register`, `read_dataN` loads `write_data`, not the old contents.
  - The bypass is suppressed when the write is dropped (register 0 with ZERO_REG=1).
- ZERO_REG=1: a read of address 0 always returns 0.
- Both ports may read the same address; both get identical data.
- IDLE, clear: with `E`=1 and `clear_start`=1:
  - Go to SWEEP, counter=0, `busy`=1 from the next cycle.
  - A `register_write` in that same cycle is dropped, since clear has priority.
  - Reads in that cycle still update normally.
- SWEEP: each cycle writes 0 to the entry at the counter, then counter+1.
  - After entry DEPTH-1 is cleared: return to IDLE, `busy`=0, counter wraps to 0.
  - `busy` is high for exactly DEPTH cycles.
  - The sweep proceeds regardless of `E`.
  - `register_write` and `clear_start` are ignored; `read_data1`/`read_data2` hold their values.
- First access after busy falls: the first accepted access in the IDLE cycle after `busy` falls sees all entries = 0.
- X handling: no X may propagate out of reset; addresses are fully decoded because DEPTH is a power of two.

Test Plan:
1. Reset then write/read: assert `reset` mid-cycle → outputs 0 immediately. Then `E`=1, write 48 to reg 22 and read reg 22 on port 2 in the same cycle → `read_data2`=48 after the edge (bypass); next cycle, reading reg 22 on port 1 → 48.
2. Enable gating: `E`=0, `register_write`=1, write 0xDEAD to reg 10 → no change. `E`=1 read reg 10 → 0. `register_write`=0 with `E`=1 → no write; outputs follow reads.
3. Register zero: ZERO_REG=1, write 0xFFFF_FFFF_FFFF_FFFF to reg 0 with a same-cycle read of reg 0 → `read_data1`=0 (no bypass). Rerun with ZERO_REG=0 → reads all-ones.
4. Bulk clear: preload reg 5=7 and reg 31=9, pulse `clear_start` → `busy` high for exactly 32 cycles. A write of 3 to reg 4 during busy is ignored, and outputs hold. After busy falls, reads of reg 5/31/4 → 0.
5. Clear/write collision and reset mid-sweep: `clear_start` and a write of 5 to reg 1 in the same cycle → reg 1 reads 0 after the sweep. Assert `reset` at sweep cycle 10 → `busy`=0 immediately; a write after release works next cycle.
6. Parameter sweep: DATA_WIDTH=8, ADDR_WIDTH=3 → write 0xA5 to reg 7, read back 0xA5; clear sweep lasts 8 cycles.
